mem_arb_seq: RTL and testbench
==============================

Name: mem_arb_seq

Overview:
- Sequencer and arbiter for a single-port 24-bit data memory.
- Shares the port between two requesters: the memory-operation pipeline stage (narrow 24-bit or wide 48-bit little-endian accesses) and a loader/debug DMA requester (24-bit, valid/ready).
- Serializes each wide access into two word cycles (lo at addr, hi at addr+1) and stalls the pipeline until the access completes.

Parameters:
- DATA_W, 24, memory word width.
- ADDR_W, 48, word address width.
- STARVE_LIMIT, 4, consecutive pipeline grants allowed while DMA is waiting; the next arbitration then goes to DMA.

Ports:
- iw_clk  input  1  clock.
- iw_rst_n  input  1  reset; one clock, synchronous, active-low.
- iw_p_req  input  1  pipeline request; held stable until ow_p_done.
- iw_p_we  input  1  pipeline write.
- iw_p_wide  input  1  48-bit access (two words).
- iw_p_addr  input  ADDR_W  word address of lo word.
- iw_p_wdata_lo  input  DATA_W  write data for addr.
- iw_p_wdata_hi  input  DATA_W  write data for addr+1.
- ow_p_rdata_lo  output  DATA_W  read data from addr.
- ow_p_rdata_hi  output  DATA_W  read data from addr+1; 0 for narrow accesses.
- ow_p_done  output  1  one-cycle completion pulse.
- ow_stall  output  1  freeze pipeline.
- iw_d_valid  input  1  DMA request valid.
- ow_d_ready  output  1  DMA request accepted this cycle.
- iw_d_we  input  1  DMA write.
- iw_d_addr  input  ADDR_W  DMA address.
- iw_d_wdata  input  DATA_W  DMA write data.
- ow_d_rvalid  output  1  DMA read data valid.
- ow_d_rdata  output  DATA_W  DMA read data.
- ow_m_en  output  1  memory access this cycle.
- ow_m_we  output  1  memory write.
- ow_m_addr  output  ADDR_W  memory address.
- ow_m_wdata  output  DATA_W  memory write data.
- iw_m_rdata  input  DATA_W  read data, valid the cycle after ow_m_en && !ow_m_we.

Behaviour:
- States: IDLE, P_LO, P_HI, P_RD, P_DONE, D_ISS, D_RD.

Reset:
- While !iw_rst_n at a clock edge: state goes to IDLE; starve counter and all latched request/data registers go to 0.
- All outputs are 0 in IDLE with no requests.
- Reset mid-operation abandons the access. A wide write may leave the lo word written and the hi word unwritten; this is accepted.

IDLE arbitration:
- Only iw_p_req: latch pipeline request, go to P_LO.
- Only iw_d_valid: ow_d_ready=1 (combinational), latch DMA request, go to D_ISS.
- Both, starve count < STARVE_LIMIT: pipeline wins, count increments.
- Both, starve count == STARVE_LIMIT: DMA wins, count clears.
- Count clears whenever iw_d_valid is low in IDLE. It saturates at STARVE_LIMIT.

Pipeline sequencing:
- P_LO: m_en=1, m_we=latched we, m_addr=addr, m_wdata=wdata_lo.
  - Wide: go to P_HI.
  - Narrow read: go to P_RD.
  - Narrow write: go to P_DONE.
- P_HI: m_addr=addr+1, wrapping modulo 2^ADDR_W; m_wdata=wdata_hi. The lo read data arriving this cycle is captured into rdata_lo. Read goes to P_RD; write goes to P_DONE.
- P_RD: iw_m_rdata is captured into rdata_hi if wide, else into rdata_lo. Go to P_DONE.
- P_DONE: ow_p_done=1, go to IDLE. rdata outputs hold until the next pipeline accept.
- Latency from accept cycle to done cycle:
  - narrow write 2
  - narrow read 3
  - wide write 3
  - wide read 4
- ow_stall = iw_p_req && !ow_p_done, combinational. It is high throughout a DMA service that blocks a pipeline request.
- A request present in the P_DONE cycle is not re-accepted. Acceptance occurs only in IDLE.

DMA sequencing:
- D_ISS: m_en=1, m_we=d_we, m_addr/m_wdata from latch. Write goes to IDLE; read goes to D_RD.
- D_RD: ow_d_rvalid=1, ow_d_rdata=iw_m_rdata (pass-through), go to IDLE.

Memory outputs:
- ow_m_* are decoded combinationally from state and latches.
- They are 0 in IDLE, P_RD, P_DONE and D_RD.

Test Plan:
- Narrow write then read: pipeline write 0x00_0010 := 0xABCDEF, done 2 cycles after accept. Then read the same address: ow_p_rdata_lo=0xABCDEF, done 3 cycles after accept, ow_stall low in the done cycle.
- Wide write/read at addr 0xFFFF_FFFF_FFFF: lo=0x111111, hi=0x222222. Hi word must go to address 0 (wrap). Wide read returns lo=0x111111, hi=0x222222 with 4-cycle latency.
- Starvation: pipeline issues back-to-back narrow requests with iw_d_valid held high. DMA is granted exactly after 4 pipeline grants (STARVE_LIMIT=4), then pipeline resumes and the counter restarts.
- DMA read only: memory preloaded 0x5A5A5A at 0x40. ow_d_ready pulses in the IDLE cycle, ow_d_rvalid with 0x5A5A5A two cycles later.
- Simultaneous first request: both requesters assert in the same cycle with count 0. Pipeline is served first; DMA is accepted in the IDLE cycle after P_DONE.
- Reset mid-operation: deassert iw_rst_n during P_HI of a wide write. Next cycle: state IDLE, all outputs 0, hi word unwritten, lo word written.

Source files
------------

// File: rtl/mem_arb_seq.sv
// Sequencer/arbiter for one single-port data memory shared by the
// memory-operation pipeline stage (narrow or two-word wide accesses) and a
// loader/debug DMA requester. Wide accesses are split into lo/hi word cycles
// and the pipeline is held in stall until its access completes.
module mem_arb_seq #(
  parameter int DATA_W       = 24,
  parameter int ADDR_W       = 48,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              iw_clk,
  input  logic              iw_rst_n,
  input  logic              iw_p_req,
  input  logic              iw_p_we,
  input  logic              iw_p_wide,
  input  logic [ADDR_W-1:0] iw_p_addr,
  input  logic [DATA_W-1:0] iw_p_wdata_lo,
  input  logic [DATA_W-1:0] iw_p_wdata_hi,
  output logic [DATA_W-1:0] ow_p_rdata_lo,
  output logic [DATA_W-1:0] ow_p_rdata_hi,
  output logic              ow_p_done,
  output logic              ow_stall,
  input  logic              iw_d_valid,
  output logic              ow_d_ready,
  input  logic              iw_d_we,
  input  logic [ADDR_W-1:0] iw_d_addr,
  input  logic [DATA_W-1:0] iw_d_wdata,
  output logic              ow_d_rvalid,
  output logic [DATA_W-1:0] ow_d_rdata,
  output logic              ow_m_en,
  output logic              ow_m_we,
  output logic [ADDR_W-1:0] ow_m_addr,
  output logic [DATA_W-1:0] ow_m_wdata,
  input  logic [DATA_W-1:0] iw_m_rdata
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  typedef enum logic [2:0] {IDLE, P_LO, P_HI, P_RD, P_DONE, D_ISS, D_RD} state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  starve_cnt;
  logic              grant_p, grant_d;
  logic              p_we_q, p_wide_q, d_we_q;
  logic [ADDR_W-1:0] p_addr_q, d_addr_q;
  logic [DATA_W-1:0] p_wlo_q, p_whi_q, d_wdata_q;
  logic [DATA_W-1:0] rdata_lo_q, rdata_hi_q;

  // Starve counter never exceeds the limit, so DMA stays owed until served.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    if (c >= CNT_MAX) return CNT_MAX;
    return c + CNT_W'(1);
  endfunction

  assign ow_p_rdata_lo = rdata_lo_q;
  assign ow_p_rdata_hi = rdata_hi_q;
  assign ow_stall      = iw_p_req && !ow_p_done;

  // Arbitration in IDLE: pipeline preferred until DMA has waited STARVE_LIMIT grants.
  always_comb begin
    grant_p = 1'b0;
    grant_d = 1'b0;
    if (state == IDLE) begin
      if (iw_p_req && (!iw_d_valid || starve_cnt < CNT_MAX)) grant_p = 1'b1;
      else if (iw_d_valid)                                   grant_d = 1'b1;
    end
  end

  // Next-state and output decode; outputs are forced low while reset is held
  // so an abandoned access cannot reach the memory on the reset edge.
  always_comb begin
    state_nxt   = state;
    ow_m_en     = 1'b0;
    ow_m_we     = 1'b0;
    ow_m_addr   = '0;
    ow_m_wdata  = '0;
    ow_p_done   = 1'b0;
    ow_d_ready  = 1'b0;
    ow_d_rvalid = 1'b0;
    ow_d_rdata  = '0;
    case (state)
      IDLE: begin
        if (grant_p) begin
          state_nxt = P_LO;
        end else if (grant_d) begin
          ow_d_ready = 1'b1;
          state_nxt  = D_ISS;
        end
      end
      P_LO: begin
        ow_m_en    = 1'b1;
        ow_m_we    = p_we_q;
        ow_m_addr  = p_addr_q;
        ow_m_wdata = p_wlo_q;
        if (p_wide_q)    state_nxt = P_HI;
        else if (p_we_q) state_nxt = P_DONE;
        else             state_nxt = P_RD;
      end
      P_HI: begin
        ow_m_en    = 1'b1;
        ow_m_we    = p_we_q;
        ow_m_addr  = p_addr_q + ADDR_W'(1);
        ow_m_wdata = p_whi_q;
        state_nxt  = p_we_q ? P_DONE : P_RD;
      end
      P_RD: state_nxt = P_DONE;
      P_DONE: begin
        ow_p_done = 1'b1;
        state_nxt = IDLE;
      end
      D_ISS: begin
        ow_m_en    = 1'b1;
        ow_m_we    = d_we_q;
        ow_m_addr  = d_addr_q;
        ow_m_wdata = d_wdata_q;
        state_nxt  = d_we_q ? IDLE : D_RD;
      end
      D_RD: begin
        ow_d_rvalid = 1'b1;
        ow_d_rdata  = iw_m_rdata;
        state_nxt   = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (!iw_rst_n) begin
      ow_m_en     = 1'b0;
      ow_m_we     = 1'b0;
      ow_m_addr   = '0;
      ow_m_wdata  = '0;
      ow_p_done   = 1'b0;
      ow_d_ready  = 1'b0;
      ow_d_rvalid = 1'b0;
      ow_d_rdata  = '0;
    end
  end

  // State register.
  always_ff @(posedge iw_clk) begin
    if (!iw_rst_n) state <= IDLE;
    else           state <= state_nxt;
  end

  // Starve counter: counts pipeline wins over a waiting DMA, clears when DMA
  // is served or not waiting.
  always_ff @(posedge iw_clk) begin
    if (!iw_rst_n) begin
      starve_cnt <= '0;
    end else if (state == IDLE) begin
      if (!iw_d_valid || grant_d) starve_cnt <= '0;
      else if (grant_p)           starve_cnt <= sat_inc(starve_cnt);
    end
  end

  // Request latches, loaded on the accepting IDLE cycle.
  always_ff @(posedge iw_clk) begin
    if (!iw_rst_n) begin
      p_we_q    <= 1'b0;
      p_wide_q  <= 1'b0;
      p_addr_q  <= '0;
      p_wlo_q   <= '0;
      p_whi_q   <= '0;
      d_we_q    <= 1'b0;
      d_addr_q  <= '0;
      d_wdata_q <= '0;
    end else begin
      if (grant_p) begin
        p_we_q   <= iw_p_we;
        p_wide_q <= iw_p_wide;
        p_addr_q <= iw_p_addr;
        p_wlo_q  <= iw_p_wdata_lo;
        p_whi_q  <= iw_p_wdata_hi;
      end
      if (grant_d) begin
        d_we_q    <= iw_d_we;
        d_addr_q  <= iw_d_addr;
        d_wdata_q <= iw_d_wdata;
      end
    end
  end

  // Pipeline read data: cleared on accept, lo captured one cycle after the lo
  // issue, hi (or narrow lo) captured in P_RD; held until the next accept.
  always_ff @(posedge iw_clk) begin
    if (!iw_rst_n) begin
      rdata_lo_q <= '0;
      rdata_hi_q <= '0;
    end else if (grant_p) begin
      rdata_lo_q <= '0;
      rdata_hi_q <= '0;
    end else if (state == P_HI && !p_we_q) begin
      rdata_lo_q <= iw_m_rdata;
    end else if (state == P_RD) begin
      if (p_wide_q) rdata_hi_q <= iw_m_rdata;
      else          rdata_lo_q <= iw_m_rdata;
    end
  end

endmodule

// File: tb/tb_mem_arb_seq.sv
// Bench for mem_arb_seq: a memory responder plus a transaction-level
// reference memory; scenario tasks drive stimulus and check inline.
module tb_mem_arb_seq;
  localparam int DATA_W = 24;
  localparam int ADDR_W = 48;
  localparam int STARVE_LIMIT = 4;

  logic              iw_clk = 1'b0;
  logic              iw_rst_n = 1'b0;
  logic              iw_p_req = 1'b0, iw_p_we = 1'b0, iw_p_wide = 1'b0;
  logic [ADDR_W-1:0] iw_p_addr = '0;
  logic [DATA_W-1:0] iw_p_wdata_lo = '0, iw_p_wdata_hi = '0;
  logic [DATA_W-1:0] ow_p_rdata_lo, ow_p_rdata_hi;
  logic              ow_p_done, ow_stall;
  logic              iw_d_valid = 1'b0, iw_d_we = 1'b0;
  logic              ow_d_ready, ow_d_rvalid;
  logic [ADDR_W-1:0] iw_d_addr = '0;
  logic [DATA_W-1:0] iw_d_wdata = '0;
  logic [DATA_W-1:0] ow_d_rdata;
  logic              ow_m_en, ow_m_we;
  logic [ADDR_W-1:0] ow_m_addr;
  logic [DATA_W-1:0] ow_m_wdata;
  logic [DATA_W-1:0] iw_m_rdata;

  int n_tests = 0;
  int n_fail  = 0;

  // memory responder state
  logic [DATA_W-1:0] mem [0:2047];
  logic              mem_clr = 1'b1;
  logic              pl_en = 1'b0;
  logic [ADDR_W-1:0] pl_addr = '0;
  logic [DATA_W-1:0] pl_data = '0;
  int                bad_addr = 0;

  // reference memory at transaction level
  logic [DATA_W-1:0] ref_mem [logic [ADDR_W-1:0]];

  mem_arb_seq #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .iw_clk(iw_clk), .iw_rst_n(iw_rst_n),
    .iw_p_req(iw_p_req), .iw_p_we(iw_p_we), .iw_p_wide(iw_p_wide), .iw_p_addr(iw_p_addr),
    .iw_p_wdata_lo(iw_p_wdata_lo), .iw_p_wdata_hi(iw_p_wdata_hi),
    .ow_p_rdata_lo(ow_p_rdata_lo), .ow_p_rdata_hi(ow_p_rdata_hi),
    .ow_p_done(ow_p_done), .ow_stall(ow_stall),
    .iw_d_valid(iw_d_valid), .ow_d_ready(ow_d_ready), .iw_d_we(iw_d_we),
    .iw_d_addr(iw_d_addr), .iw_d_wdata(iw_d_wdata),
    .ow_d_rvalid(ow_d_rvalid), .ow_d_rdata(ow_d_rdata),
    .ow_m_en(ow_m_en), .ow_m_we(ow_m_we), .ow_m_addr(ow_m_addr),
    .ow_m_wdata(ow_m_wdata), .iw_m_rdata(iw_m_rdata)
  );

  always #5 iw_clk = ~iw_clk;

  // Bench addresses live near 0 or near the top of the space; fold them into a small array.
  function automatic int midx(input logic [ADDR_W-1:0] a);
    return int'({a[ADDR_W-1], a[9:0]});
  endfunction

  function automatic logic [DATA_W-1:0] ref_rd(input logic [ADDR_W-1:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : '0;
  endfunction

  function automatic logic [ADDR_W-1:0] rnd_addr();
    if ($urandom_range(0, 1) == 1) return ADDR_W'($urandom_range(0, 31));
    return {ADDR_W{1'b1}} - ADDR_W'($urandom_range(0, 7));
  endfunction

  // Single-port memory: registered read data one cycle after a read issue,
  // junk on other cycles.
  always @(posedge iw_clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 2048; i++) mem[i] <= '0;
    end else if (pl_en) begin
      mem[midx(pl_addr)] <= pl_data;
    end
    if (ow_m_en && ow_m_we) mem[midx(ow_m_addr)] <= ow_m_wdata;
    if (ow_m_en && (ow_m_addr[ADDR_W-2:10] != {(ADDR_W-11){ow_m_addr[ADDR_W-1]}}))
      bad_addr <= bad_addr + 1;
    iw_m_rdata <= (ow_m_en && !ow_m_we) ? mem[midx(ow_m_addr)] : DATA_W'($urandom);
  end

  task automatic preload(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    @(negedge iw_clk);
    pl_addr = a; pl_data = d; pl_en = 1'b1;
    @(negedge iw_clk);
    pl_en = 1'b0;
    ref_mem[a] = d;
  endtask

  task automatic pipe_op(input logic we, input logic wide, input logic [ADDR_W-1:0] a,
                         input logic [DATA_W-1:0] lo, input logic [DATA_W-1:0] hi,
                         input string tag);
    int lat, exp_lat;
    logic stall_ok;
    logic [ADDR_W-1:0] a1;
    logic [DATA_W-1:0] e_lo, e_hi;
    a1 = a + 1'b1;
    exp_lat = we ? (wide ? 3 : 2) : (wide ? 4 : 3);
    e_lo = ref_rd(a);
    e_hi = wide ? ref_rd(a1) : '0;
    @(negedge iw_clk);
    iw_p_req = 1'b1; iw_p_we = we; iw_p_wide = wide; iw_p_addr = a;
    iw_p_wdata_lo = lo; iw_p_wdata_hi = hi;
    #1;
    lat = 0; stall_ok = 1'b1;
    while (!ow_p_done && lat < 20) begin
      if (!ow_stall) stall_ok = 1'b0;
      @(negedge iw_clk); #1;
      lat++;
    end
    n_tests++;
    if (lat !== exp_lat) begin
      n_fail++;
      $display("FAIL %s latency: got %0d expected %0d", tag, lat, exp_lat);
    end
    n_tests++;
    if ({stall_ok, ow_stall} !== 2'b10) begin
      n_fail++;
      $display("FAIL %s stall: got held=%b done_cycle=%b expected held=1 done_cycle=0", tag, stall_ok, ow_stall);
    end
    if (!we) begin
      n_tests++;
      if ({ow_p_rdata_hi, ow_p_rdata_lo} !== {e_hi, e_lo}) begin
        n_fail++;
        $display("FAIL %s rdata: got hi=%h lo=%h expected hi=%h lo=%h", tag, ow_p_rdata_hi, ow_p_rdata_lo, e_hi, e_lo);
      end
    end else begin
      ref_mem[a] = lo;
      if (wide) ref_mem[a1] = hi;
    end
    iw_p_req = 1'b0;
  endtask

  task automatic dma_op(input logic we, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] wd,
                        input string tag);
    logic [DATA_W-1:0] e;
    e = ref_rd(a);
    @(negedge iw_clk);
    iw_d_valid = 1'b1; iw_d_we = we; iw_d_addr = a; iw_d_wdata = wd;
    #1;
    n_tests++;
    if (ow_d_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s ready: got %b expected 1", tag, ow_d_ready);
    end
    @(negedge iw_clk);
    iw_d_valid = 1'b0;
    #1;
    if (!we) begin
      @(negedge iw_clk); #1;
      n_tests++;
      if ({ow_d_rvalid, ow_d_rdata} !== {1'b1, e}) begin
        n_fail++;
        $display("FAIL %s rdata: got rvalid=%b data=%h expected rvalid=1 data=%h", tag, ow_d_rvalid, ow_d_rdata, e);
      end
    end else begin
      ref_mem[a] = wd;
    end
  endtask

  task automatic test_reset;
    iw_rst_n = 1'b0; mem_clr = 1'b1;
    repeat (3) @(negedge iw_clk);
    mem_clr = 1'b0;
    #1;
    n_tests++;
    if ({ow_p_rdata_lo, ow_p_rdata_hi, ow_p_done, ow_stall, ow_d_ready, ow_d_rvalid, ow_d_rdata,
         ow_m_en, ow_m_we, ow_m_addr, ow_m_wdata} !== '0) begin
      n_fail++;
      $display("FAIL reset_hold outputs: got m_en=%b done=%b ready=%b expected all zero", ow_m_en, ow_p_done, ow_d_ready);
    end
    @(negedge iw_clk);
    iw_rst_n = 1'b1;
    #1;
    n_tests++;
    if ({ow_p_rdata_lo, ow_p_rdata_hi, ow_p_done, ow_stall, ow_d_ready, ow_d_rvalid, ow_d_rdata,
         ow_m_en, ow_m_we, ow_m_addr, ow_m_wdata} !== '0) begin
      n_fail++;
      $display("FAIL reset_idle outputs: got m_en=%b done=%b ready=%b lo=%h expected all zero", ow_m_en, ow_p_done, ow_d_ready, ow_p_rdata_lo);
    end
  endtask

  task automatic test_narrow;
    pipe_op(1'b1, 1'b0, 48'h10, 24'hABCDEF, 24'h0, "narrow_wr");
    pipe_op(1'b0, 1'b0, 48'h10, 24'h0, 24'h0, "narrow_rd");
  endtask

  task automatic test_wide_wrap;
    pipe_op(1'b1, 1'b1, 48'hFFFF_FFFF_FFFF, 24'h111111, 24'h222222, "wide_wr");
    n_tests++;
    if (mem[midx(48'h0)] !== 24'h222222) begin
      n_fail++;
      $display("FAIL wide_wrap hi_at_0: got %h expected 222222", mem[midx(48'h0)]);
    end
    pipe_op(1'b0, 1'b1, 48'hFFFF_FFFF_FFFF, 24'h0, 24'h0, "wide_rd");
  endtask

  task automatic test_dma_read;
    preload(48'h40, 24'h5A5A5A);
    dma_op(1'b0, 48'h40, 24'h0, "dma_rd");
  endtask

  task automatic test_random;
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 2))
        0: pipe_op(1'b0, 1'($urandom_range(0, 1)), rnd_addr(), 24'h0, 24'h0, "rnd_pipe_rd");
        1: pipe_op(1'b1, 1'($urandom_range(0, 1)), rnd_addr(), DATA_W'($urandom), DATA_W'($urandom), "rnd_pipe_wr");
        default: dma_op(1'($urandom_range(0, 1)), rnd_addr(), DATA_W'($urandom), "rnd_dma");
      endcase
    end
  endtask

  task automatic test_starve;
    logic [11:0] exp_bits, got_bits;
    int cnt, n_ev, cyc;
    logic stall_ok;
    logic [ADDR_W-1:0] pa;
    // grant order implied by the starvation rule: 1 = pipeline, 0 = DMA
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      if (cnt == STARVE_LIMIT) begin exp_bits[i] = 1'b0; cnt = 0; end
      else begin exp_bits[i] = 1'b1; cnt++; end
    end
    got_bits = '0; n_ev = 0; cyc = 0; stall_ok = 1'b1;
    pa = 48'h200;
    @(negedge iw_clk);
    iw_p_req = 1'b1; iw_p_we = 1'b1; iw_p_wide = 1'($urandom_range(0, 1)); iw_p_addr = pa;
    iw_p_wdata_lo = DATA_W'($urandom); iw_p_wdata_hi = DATA_W'($urandom);
    iw_d_valid = 1'b1; iw_d_we = 1'b0; iw_d_addr = 48'h40;
    #1;
    while (n_ev < 12 && cyc < 300) begin
      if (ow_d_ready) begin
        got_bits[n_ev] = 1'b0; n_ev++;
        if (!ow_stall) stall_ok = 1'b0;
      end else if (ow_p_done) begin
        got_bits[n_ev] = 1'b1; n_ev++;
        ref_mem[iw_p_addr] = iw_p_wdata_lo;
        if (iw_p_wide) ref_mem[iw_p_addr + 1'b1] = iw_p_wdata_hi;
        pa = pa + 48'd2;
        iw_p_addr = pa; iw_p_wide = 1'($urandom_range(0, 1));
        iw_p_wdata_lo = DATA_W'($urandom); iw_p_wdata_hi = DATA_W'($urandom);
      end
      if (n_ev < 12) begin
        @(negedge iw_clk); #1;
        cyc++;
      end
    end
    iw_p_req = 1'b0; iw_d_valid = 1'b0;
    n_tests++;
    if (got_bits !== exp_bits || n_ev != 12) begin
      n_fail++;
      $display("FAIL starve order: got %b (%0d events) expected %b", got_bits, n_ev, exp_bits);
    end
    n_tests++;
    if (stall_ok !== 1'b1) begin
      n_fail++;
      $display("FAIL starve stall_during_dma: got %b expected 1", stall_ok);
    end
    repeat (3) @(negedge iw_clk);
  endtask

  task automatic test_simultaneous;
    int lat;
    logic [DATA_W-1:0] e;
    e = ref_rd(48'h10);
    @(negedge iw_clk);
    iw_p_req = 1'b1; iw_p_we = 1'b1; iw_p_wide = 1'b0; iw_p_addr = 48'h300; iw_p_wdata_lo = 24'h3C3C3C;
    iw_d_valid = 1'b1; iw_d_we = 1'b0; iw_d_addr = 48'h10;
    #1;
    n_tests++;
    if ({ow_d_ready, ow_stall} !== 2'b01) begin
      n_fail++;
      $display("FAIL simul first_grant: got ready=%b stall=%b expected ready=0 stall=1", ow_d_ready, ow_stall);
    end
    lat = 0;
    while (!ow_p_done && lat < 20) begin
      @(negedge iw_clk); #1;
      lat++;
    end
    n_tests++;
    if (lat !== 2) begin
      n_fail++;
      $display("FAIL simul pipe_latency: got %0d expected 2", lat);
    end
    ref_mem[48'h300] = 24'h3C3C3C;
    iw_p_req = 1'b0;
    @(negedge iw_clk); #1;
    n_tests++;
    if (ow_d_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL simul dma_after_done: got ready=%b expected 1", ow_d_ready);
    end
    @(negedge iw_clk);
    iw_d_valid = 1'b0;
    iw_p_req = 1'b1; iw_p_we = 1'b0; iw_p_wide = 1'b0; iw_p_addr = 48'h300;
    #1;
    n_tests++;
    if (ow_stall !== 1'b1) begin
      n_fail++;
      $display("FAIL simul blocked_stall: got %b expected 1", ow_stall);
    end
    @(negedge iw_clk); #1;
    n_tests++;
    if ({ow_d_rvalid, ow_d_rdata, ow_stall} !== {1'b1, e, 1'b1}) begin
      n_fail++;
      $display("FAIL simul dma_rdata: got rvalid=%b data=%h stall=%b expected rvalid=1 data=%h stall=1", ow_d_rvalid, ow_d_rdata, ow_stall, e);
    end
    pipe_op(1'b0, 1'b0, 48'h300, 24'h0, 24'h0, "simul_blocked_rd");
  endtask

  task automatic test_reset_mid;
    preload(48'h101, 24'h777777);
    @(negedge iw_clk);
    iw_p_req = 1'b1; iw_p_we = 1'b1; iw_p_wide = 1'b1; iw_p_addr = 48'h100;
    iw_p_wdata_lo = 24'hAAAAAA; iw_p_wdata_hi = 24'hBBBBBB;
    @(negedge iw_clk); #1;
    @(negedge iw_clk); #1;
    n_tests++;
    if ({ow_m_en, ow_m_we, ow_m_addr} !== {1'b1, 1'b1, 48'h101}) begin
      n_fail++;
      $display("FAIL rst_mid in_p_hi: got en=%b we=%b addr=%h expected en=1 we=1 addr=000000000101", ow_m_en, ow_m_we, ow_m_addr);
    end
    iw_rst_n = 1'b0; iw_p_req = 1'b0;
    @(negedge iw_clk); #1;
    n_tests++;
    if ({ow_p_rdata_lo, ow_p_rdata_hi, ow_p_done, ow_stall, ow_d_ready, ow_d_rvalid, ow_d_rdata,
         ow_m_en, ow_m_we, ow_m_addr, ow_m_wdata} !== '0) begin
      n_fail++;
      $display("FAIL rst_mid outputs: got m_en=%b m_addr=%h done=%b expected all zero", ow_m_en, ow_m_addr, ow_p_done);
    end
    iw_rst_n = 1'b1;
    n_tests++;
    if ({mem[midx(48'h100)], mem[midx(48'h101)]} !== {24'hAAAAAA, 24'h777777}) begin
      n_fail++;
      $display("FAIL rst_mid memory: got lo=%h hi=%h expected lo=aaaaaa hi=777777", mem[midx(48'h100)], mem[midx(48'h101)]);
    end
    ref_mem[48'h100] = 24'hAAAAAA;
    pipe_op(1'b0, 1'b1, 48'h100, 24'h0, 24'h0, "rst_mid_recover");
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_narrow();
    test_wide_wrap();
    test_dma_read();
    test_random();
    test_starve();
    test_simultaneous();
    test_reset_mid();
    n_tests++;
    if (bad_addr !== 0) begin
      n_fail++;
      $display("FAIL stray_addr: got %0d out-of-range accesses expected 0", bad_addr);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
